l2_request_arbiter: RTL and testbench

//  Two-master to one-slave arbiter directly upstream of the L2 cache.
//  - Merges the L1 I-cache miss port and the L1 D-cache miss port onto the single proc-side generic bus of l2_cache.
//  - Serialises the two ports one transaction at a time, with round-robin or fixed priority.
//  - Each master sees standard generic_bus busy/rdata semantics, as if it owned the L2.

---
 rtl/l2_request_arbiter_if.sv | 21 ++
 rtl/l2_request_arbiter.sv | 96 +++++++++
 tb/tb_l2_request_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_request_arbiter_if.sv
// Generic request/busy bus between a cache-side requester and the L2 proc port.
// generic_bus modport faces the requester; cpu modport drives the L2.
interface generic_bus;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ren;
   logic        wen;
   logic        busy;
   logic [3:0]  byte_en;

   modport generic_bus (
      input  addr, wdata, ren, wen, byte_en,
      output rdata, busy
   );

   modport cpu (
      output addr, wdata, ren, wen, byte_en,
      input  rdata, busy
   );
endinterface

// File: rtl/l2_request_arbiter.sv
// I/D miss-port arbiter onto the single L2 proc bus; one registered arbitration cycle, then L2 latency.
// Losing/idle master is held off with busy=1; the granted master sees the L2 busy/rdata directly.
module l2_request_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter bit RESET_LAST  = 1'b0
) (
   input logic             CLK,
   input logic             nRST,
   generic_bus.generic_bus icache_bus_if,
   generic_bus.generic_bus dcache_bus_if,
   generic_bus.cpu         l2_bus_if
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   state_t state;
   logic   last_grant;
   logic   req_i;
   logic   req_d;

   assign req_i = icache_bus_if.ren | icache_bus_if.wen;
   assign req_d = dcache_bus_if.ren | dcache_bus_if.wen;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         last_grant <= RESET_LAST;
      end else begin
         case (state)
            IDLE: begin
               if (req_i && req_d) begin
                  // last_grant: 0 = I-cache, 1 = D-cache
                  if (ROUND_ROBIN) state <= last_grant ? GRANT_I : GRANT_D;
                  else             state <= GRANT_D;
               end else if (req_d) begin
                  state <= GRANT_D;
               end else if (req_i) begin
                  state <= GRANT_I;
               end
            end
            GRANT_I: begin
               if (!req_i) begin
                  state <= IDLE;
               end else if (!l2_bus_if.busy) begin
                  state      <= IDLE;
                  last_grant <= 1'b0;
               end
            end
            GRANT_D: begin
               if (!req_d) begin
                  state <= IDLE;
               end else if (!l2_bus_if.busy) begin
                  state      <= IDLE;
                  last_grant <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Forwarding is combinational so an aborting master drops the L2 strobe in the same cycle.
   always_comb begin
      l2_bus_if.addr        = '0;
      l2_bus_if.wdata       = '0;
      l2_bus_if.ren         = 1'b0;
      l2_bus_if.wen         = 1'b0;
      l2_bus_if.byte_en     = '0;
      icache_bus_if.busy    = 1'b1;
      icache_bus_if.rdata   = '0;
      dcache_bus_if.busy    = 1'b1;
      dcache_bus_if.rdata   = '0;
      case (state)
         GRANT_I: begin
            l2_bus_if.addr      = icache_bus_if.addr;
            l2_bus_if.wdata     = icache_bus_if.wdata;
            l2_bus_if.ren       = icache_bus_if.ren;
            l2_bus_if.wen       = icache_bus_if.wen;
            l2_bus_if.byte_en   = icache_bus_if.byte_en;
            icache_bus_if.busy  = l2_bus_if.busy;
            icache_bus_if.rdata = l2_bus_if.rdata;
         end
         GRANT_D: begin
            l2_bus_if.addr      = dcache_bus_if.addr;
            l2_bus_if.wdata     = dcache_bus_if.wdata;
            l2_bus_if.ren       = dcache_bus_if.ren;
            l2_bus_if.wen       = dcache_bus_if.wen;
            l2_bus_if.byte_en   = dcache_bus_if.byte_en;
            dcache_bus_if.busy  = l2_bus_if.busy;
            dcache_bus_if.rdata = l2_bus_if.rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: round-robin instance plus a fixed-priority instance,
// each behind a simple L2 model whose busy drops after a programmable number of active cycles.
module tb_l2_request_arbiter;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [31:0] rdata_val = 32'h0;
   int          lat = 1;
   int          lat_f = 1;
   int          cnt;
   int          cnt_f;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          gq[$];
   int          gt[$];

   generic_bus ibus();
   generic_bus dbus();
   generic_bus l2bus();
   generic_bus ibus_f();
   generic_bus dbus_f();
   generic_bus l2bus_f();

   l2_request_arbiter #(.ROUND_ROBIN(1'b1), .RESET_LAST(1'b0)) dut (
      .CLK(CLK), .nRST(nRST),
      .icache_bus_if(ibus), .dcache_bus_if(dbus), .l2_bus_if(l2bus)
   );

   l2_request_arbiter #(.ROUND_ROBIN(1'b0), .RESET_LAST(1'b0)) dut_fp (
      .CLK(CLK), .nRST(nRST),
      .icache_bus_if(ibus_f), .dcache_bus_if(dbus_f), .l2_bus_if(l2bus_f)
   );

   always #5 CLK = ~CLK;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                      cnt <= 0;
      else if (l2bus.ren || l2bus.wen) cnt <= cnt + 1;
      else                            cnt <= 0;
   end
   assign l2bus.busy  = !((l2bus.ren || l2bus.wen) && cnt >= lat);
   assign l2bus.rdata = l2bus.busy ? 32'h0 : rdata_val;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                          cnt_f <= 0;
      else if (l2bus_f.ren || l2bus_f.wen) cnt_f <= cnt_f + 1;
      else                                cnt_f <= 0;
   end
   assign l2bus_f.busy  = !((l2bus_f.ren || l2bus_f.wen) && cnt_f >= lat_f);
   assign l2bus_f.rdata = l2bus_f.busy ? 32'h0 : 32'hCAFE_0000;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_all();
      ibus.ren = 0;   ibus.wen = 0;   ibus.addr = 0;   ibus.wdata = 0;   ibus.byte_en = 0;
      dbus.ren = 0;   dbus.wen = 0;   dbus.addr = 0;   dbus.wdata = 0;   dbus.byte_en = 0;
      ibus_f.ren = 0; ibus_f.wen = 0; ibus_f.addr = 0; ibus_f.wdata = 0; ibus_f.byte_en = 0;
      dbus_f.ren = 0; dbus_f.wen = 0; dbus_f.addr = 0; dbus_f.wdata = 0; dbus_f.byte_en = 0;
   endtask

   task automatic do_reset();
      idle_all();
      nRST = 1'b0;
      repeat (2) step();
      nRST = 1'b1;
      step();
   endtask

   // Runs n cycles on the round-robin instance, logging each completion (1 = D, 0 = I) and its cycle.
   // With oneshot set, a master drops its request right after the edge that completes it.
   task automatic run_cycles(input int n, input bit oneshot);
      bit i_done;
      bit d_done;
      gq.delete();
      gt.delete();
      for (int k = 0; k < n; k++) begin
         i_done = (ibus.ren || ibus.wen) && !ibus.busy;
         d_done = (dbus.ren || dbus.wen) && !dbus.busy;
         if (i_done) begin gq.push_back(1'b0); gt.push_back(k); end
         if (d_done) begin gq.push_back(1'b1); gt.push_back(k); end
         step();
         if (oneshot && i_done) begin ibus.ren = 0; ibus.wen = 0; end
         if (oneshot && d_done) begin dbus.ren = 0; dbus.wen = 0; end
      end
   endtask

   function automatic logic [7:0] packq();
      logic [7:0] v = '0;
      for (int k = 0; k < gq.size() && k < 8; k++) v[k] = gq[k];
      return v;
   endfunction

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({l2bus.ren, l2bus.wen, l2bus.addr, l2bus.wdata, l2bus.byte_en} !== 70'h0) begin
         n_fail++;
         $display("FAIL reset_l2_outputs: got ren=%b wen=%b addr=%h wdata=%h be=%h, expected all zero",
                  l2bus.ren, l2bus.wen, l2bus.addr, l2bus.wdata, l2bus.byte_en);
      end
      n_checks++;
      if ({ibus.busy, dbus.busy, ibus.rdata, dbus.rdata} !== {1'b1, 1'b1, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_master_outputs: got ibusy=%b dbusy=%b irdata=%h drdata=%h, expected 1 1 0 0",
                  ibus.busy, dbus.busy, ibus.rdata, dbus.rdata);
      end
   endtask

   task automatic test_lone_read();
      do_reset();
      lat = 1;
      rdata_val = 32'hDEAD_BEEF;
      ibus.ren = 1; ibus.addr = 32'h0000_0100;
      n_checks++;
      if ({l2bus.ren, l2bus.addr} !== 33'h0) begin
         n_fail++;
         $display("FAIL lone_read_idle_cycle: got l2 ren=%b addr=%h, expected 0 0", l2bus.ren, l2bus.addr);
      end
      step();
      n_checks++;
      if ({l2bus.ren, l2bus.addr, ibus.busy, dbus.busy} !== {1'b1, 32'h0000_0100, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL lone_read_cycle1: got l2 ren=%b addr=%h ibusy=%b dbusy=%b, expected 1 00000100 1 1",
                  l2bus.ren, l2bus.addr, ibus.busy, dbus.busy);
      end
      step();
      n_checks++;
      if ({ibus.busy, ibus.rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL lone_read_done: got ibusy=%b irdata=%h, expected 0 deadbeef", ibus.busy, ibus.rdata);
      end
      n_checks++;
      if ({dbus.busy, dbus.rdata} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL lone_read_d_masked: got dbusy=%b drdata=%h, expected 1 00000000", dbus.busy, dbus.rdata);
      end
      step();
      ibus.ren = 0;
      n_checks++;
      if ({l2bus.ren, ibus.busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL lone_read_gap: got l2 ren=%b ibusy=%b, expected 0 1", l2bus.ren, ibus.busy);
      end
      step();
   endtask

   task automatic test_contention();
      do_reset();
      lat = 1;
      ibus.ren = 1; ibus.addr = 32'h0000_0100;
      dbus.ren = 1; dbus.addr = 32'h0000_0200;
      run_cycles(8, 1'b1);
      n_checks++;
      if (gq.size() != 2 || packq() !== 8'b0000_0001) begin
         n_fail++;
         $display("FAIL contention_order: got %0d grants seq=%b, expected 2 grants seq=00000001 (D then I)",
                  gq.size(), packq());
      end
      n_checks++;
      if (gt.size() != 2 || gt[0] != 2 || gt[1] != 5) begin
         n_fail++;
         $display("FAIL contention_timing: got %0d completions, first two at cycles %0d,%0d, expected 2 at 2,5",
                  gt.size(), (gt.size() > 0) ? gt[0] : -1, (gt.size() > 1) ? gt[1] : -1);
      end
   endtask

   // Continues from test_contention: last grant is I, so the D-cache wins first.
   task automatic test_back_to_back();
      ibus.ren = 1; ibus.addr = 32'h0000_0140;
      dbus.ren = 1; dbus.addr = 32'h0000_0240;
      run_cycles(12, 1'b0);
      n_checks++;
      if (gq.size() != 4 || packq() !== 8'b0000_0101) begin
         n_fail++;
         $display("FAIL rr_alternation: got %0d grants seq=%b, expected 4 grants seq=00000101 (D,I,D,I)",
                  gq.size(), packq());
      end
      n_checks++;
      if (gt.size() != 4 || gt[3] != 11) begin
         n_fail++;
         $display("FAIL rr_idle_gap: got %0d completions, last at %0d, expected 4 with last at cycle 11",
                  gt.size(), (gt.size() > 3) ? gt[3] : -1);
      end
      idle_all();
      repeat (2) step();
   endtask

   task automatic test_fixed_priority();
      int i_cnt = 0;
      int d_cnt = 0;
      lat_f = 1;
      ibus_f.ren = 1; ibus_f.addr = 32'h0000_0100;
      dbus_f.ren = 1; dbus_f.addr = 32'h0000_0200;
      for (int k = 0; k < 12; k++) begin
         if (!ibus_f.busy) i_cnt++;
         if (!dbus_f.busy) d_cnt++;
         step();
      end
      n_checks++;
      if (i_cnt != 0 || d_cnt != 4) begin
         n_fail++;
         $display("FAIL fixed_priority_d_wins: got I=%0d D=%0d completions, expected I=0 D=4", i_cnt, d_cnt);
      end
      dbus_f.ren = 0;
      i_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (!ibus_f.busy) i_cnt++;
         step();
      end
      n_checks++;
      if (i_cnt != 2) begin
         n_fail++;
         $display("FAIL fixed_priority_i_alone: got I=%0d completions, expected 2", i_cnt);
      end
      idle_all();
      repeat (2) step();
   endtask

   task automatic test_d_write();
      do_reset();
      lat = 3;
      dbus.wen = 1; dbus.addr = 32'h0000_2004; dbus.wdata = 32'h1234_5678; dbus.byte_en = 4'b0011;
      step();
      n_checks++;
      if ({l2bus.addr, l2bus.wdata, l2bus.byte_en, l2bus.wen, l2bus.ren} !==
          {32'h0000_2004, 32'h1234_5678, 4'b0011, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL d_write_forward: got addr=%h wdata=%h be=%b wen=%b ren=%b, expected 00002004 12345678 0011 1 0",
                  l2bus.addr, l2bus.wdata, l2bus.byte_en, l2bus.wen, l2bus.ren);
      end
      for (int c = 1; c <= 4; c++) begin
         n_checks++;
         if ({dbus.busy, ibus.busy} !== {(c != 4), 1'b1}) begin
            n_fail++;
            $display("FAIL d_write_busy_c%0d: got dbusy=%b ibusy=%b, expected %b 1",
                     c, dbus.busy, ibus.busy, (c != 4));
         end
         if (c < 4) step();
      end
      step();
      dbus.wen = 0;
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      lat = 100;
      rdata_val = 32'h5555_AAAA;
      ibus.ren = 1; ibus.addr = 32'h0000_0300;
      repeat (2) step();
      n_checks++;
      if ({l2bus.ren, ibus.busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_mid_granted: got l2 ren=%b ibusy=%b, expected 1 1", l2bus.ren, ibus.busy);
      end
      nRST = 1'b0;
      #1;
      n_checks++;
      if ({l2bus.ren, l2bus.wen, ibus.busy, dbus.busy, ibus.rdata} !== {4'b0011, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_async: got l2 ren=%b wen=%b ibusy=%b dbusy=%b irdata=%h, expected 0 0 1 1 0",
                  l2bus.ren, l2bus.wen, ibus.busy, dbus.busy, ibus.rdata);
      end
      step();
      n_checks++;
      if ({l2bus.ren, ibus.busy, dbus.busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL reset_mid_edge: got l2 ren=%b ibusy=%b dbusy=%b, expected 0 1 1",
                  l2bus.ren, ibus.busy, dbus.busy);
      end
      ibus.ren = 0;
      nRST = 1'b1;
      step();
      lat = 1;
      ibus.ren = 1; dbus.ren = 1;
      run_cycles(4, 1'b1);
      n_checks++;
      if (gq.size() != 1 || gq[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_first_contention: got %0d grants seq=%b, expected 1 grant to D",
                  gq.size(), packq());
      end
      run_cycles(4, 1'b1);
      idle_all();
      step();
   endtask

   task automatic test_abort();
      do_reset();
      lat = 100;
      ibus.ren = 1; ibus.addr = 32'h0000_0400;
      repeat (2) step();
      ibus.ren = 0;
      #1;
      n_checks++;
      if (l2bus.ren !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_ren_falls: got l2 ren=%b, expected 0", l2bus.ren);
      end
      repeat (2) step();
      lat = 1;
      ibus.ren = 1; dbus.ren = 1;
      run_cycles(8, 1'b1);
      n_checks++;
      if (gq.size() != 2 || packq() !== 8'b0000_0001) begin
         n_fail++;
         $display("FAIL abort_from_reset: got %0d grants seq=%b, expected 2 grants seq=00000001 (D then I)",
                  gq.size(), packq());
      end
      // Make D the last winner, then abort an I grant: the next contention must go to I.
      dbus.ren = 1;
      run_cycles(4, 1'b1);
      lat = 100;
      ibus.ren = 1;
      repeat (2) step();
      ibus.ren = 0;
      repeat (2) step();
      lat = 1;
      ibus.ren = 1; dbus.ren = 1;
      run_cycles(8, 1'b1);
      n_checks++;
      if (gq.size() != 2 || packq() !== 8'b0000_0010) begin
         n_fail++;
         $display("FAIL abort_keeps_last: got %0d grants seq=%b, expected 2 grants seq=00000010 (I then D)",
                  gq.size(), packq());
      end
      idle_all();
      step();
   endtask

   initial begin
      idle_all();
      test_reset();
      test_lone_read();
      test_contention();
      test_back_to_back();
      test_fixed_priority();
      test_d_write();
      test_reset_mid();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before end of test");
      $fatal(1, "timeout");
   end

endmodule
